bcd_mod_counter: RTL and testbench
==================================

# bcd_mod_counter

Parametrised modulo-N BCD counter with a configurable number of decimal digits, count direction, enable and validated synchronous load. It generalises the fixed two-digit mod-60 seconds counter into one reusable block. Typical instances are seconds and minutes (mod 60), hours (mod 24) and event counters (mod 10^k). A registered wrap pulse lets instances be cascaded into clock/timer chains.

## Interface
- DIGITS, 2, number of BCD digits; legal range 1..4
- MODULUS, 60, count modulus; legal range 2..10^DIGITS; count range is 0..MODULUS-1
- clk  in  1  rising-edge clock
- _rst  in  1  asynchronous, active-low reset
- en  in  1  count enable; one step per clock while high
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous load strobe
- din  in  4*DIGITS  BCD load value; din[3:0] is the units digit
- Q  out  4*DIGITS  current count in BCD; Q[3:0] units, Q[7:4] tens, and so on
- wrap  out  1  one-cycle pulse: the count rolled over at the last edge
- err  out  1  one-cycle pulse: the last load was rejected

## Operation
- Reset: while _rst=0, Q=0, wrap=0, err=0, regardless of clk; asynchronous assert, synchronous (edge-driven) operation after release.
- Priority per edge: load > en > hold.
- Load, valid: every nibble of din is 0..9 and value(din) < MODULUS. Q <= din, wrap <= 0, err <= 0.
- Load, invalid: a nibble is above 9, or value(din) >= MODULUS. Q is unchanged, err <= 1, wrap <= 0.
- Count up (en=1, up=1, load=0):
  - Q == MODULUS-1: Q <= 0, wrap <= 1.
  - Otherwise: BCD increment. A units digit at 9 becomes 0 and carries into the next digit, and so on up the chain. wrap <= 0.
- Count down (en=1, up=0, load=0):
  - Q == 0: Q <= MODULUS-1 in BCD, wrap <= 1.
  - Otherwise: BCD decrement. A digit at 0 becomes 9 and borrows from the next digit. wrap <= 0.
- Hold (en=0, load=0): Q unchanged, wrap <= 0, err <= 0.
- Arithmetic is digit-wise BCD only. Q never holds a non-BCD nibble and never holds a value >= MODULUS.
- The terminal comparison uses the decimal value of Q. Example: MODULUS=24, DIGITS=2 wraps up-count from 0x23 to 0x00.
- Direction may change on any cycle. The new direction applies from the next edge, with no extra latency.
- Cascading: the next stage's en is driven by this stage's wrap. The next stage therefore steps one cycle after the rollover. This fixed one-cycle skew per stage is by design.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: load or count takes effect at the first rising edge where it is sampled. Q is valid after that edge.
- wrap and err are high for exactly one cycle, the cycle after the causing edge. They stay high only if the next edge again wraps or rejects.
- With en held high and load=0, wrap pulses exactly once every MODULUS cycles.
- Reset asserted mid-count clears all outputs immediately, including a pending wrap or err pulse.
- First active edge after release: the edge at which _rst is sampled high acts normally.

## Test plan
- Reset and up-count, defaults (DIGITS=2, MODULUS=60):
  - Stimulus: _rst=0 for 20 ns, release, en=1, up=1.
  - Required: Q steps 0x00 through 0x09, then 0x10 (never 0x0A), continuing to 0x59.
  - Required: the 60th edge gives Q=0x00 with wrap=1 for one cycle. No other wrap pulse occurs in the 60 cycles.
- Down-count from 0x00, defaults:
  - Required: next Q=0x59 with wrap=1.
  - Required: the sequence continues 0x58 … 0x50, 0x49 (borrow across digits).
- Load:
  - din=0x45 → Q=0x45 next cycle, err=0.
  - din=0x60 → err=1 for one cycle, Q unchanged.
  - din=0x3A → err=1, Q unchanged.
  - load=1 together with en=1 → the load wins.
- Hold and mid-count reset:
  - en=0 for 5 cycles at Q=0x37 → Q stays 0x37, wrap=0.
  - _rst pulsed low between clock edges at Q=0x59 → Q=0x00 and wrap=0 immediately, with no edge needed.
- Variant DIGITS=2, MODULUS=24, up-count:
  - Required: 0x23 → 0x00 with wrap=1.
  - Required: load of 0x24 is rejected (err=1).
- Variant DIGITS=3, MODULUS=1000, cascade check:
  - Stimulus: load 0x998, count up.
  - Required: 0x999, then 0x000 with wrap=1.
  - Required: a second instance with its en driven by this wrap increments exactly one cycle after the rollover.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: modulo-MODULUS counter held as DIGITS packed BCD digits.
// Counts up or down, loads a validated BCD value, and emits registered
// one-cycle wrap and load-reject pulses. Use wrap as the next stage's en to
// cascade counters.
//
// Ports:
//   clk   rising-edge clock
//   _rst  asynchronous active-low reset
//   en    count enable, one step per clock
//   up    direction, 1 = increment, 0 = decrement
//   load  synchronous load strobe; takes priority over en
//   din   BCD load value, din[3:0] is the units digit
//   Q     current count in BCD
//   wrap  one-cycle pulse after a rollover edge
//   err   one-cycle pulse after a rejected load
module bcd_mod_counter #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MODULUS = 60
) (
    input  logic                  clk,
    input  logic                  _rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  wrap,
    output logic                  err
);

    localparam int unsigned W = 4 * DIGITS;

    // Binary to packed BCD.
    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    // Decimal value of a packed BCD word.
    function automatic int unsigned bcd_value(input logic [W-1:0] b);
        int unsigned acc;
        acc = 0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            acc = acc * 10 + 32'(b[4*i +: 4]);
        end
        return acc;
    endfunction

    // True when every nibble is a decimal digit.
    function automatic logic bcd_valid(input logic [W-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (b[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Digit-wise increment; a 9 rolls to 0 and carries upward.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         carry;
        r     = b;
        carry = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (b[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = b[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Digit-wise decrement; a 0 rolls to 9 and borrows upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         borrow;
        r      = b;
        borrow = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (b[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = b[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Terminal count in BCD; since Q is always valid BCD, an equality test
    // against this word is the same as comparing decimal values.
    localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

    logic [W-1:0] q_r;
    logic [W-1:0] q_nxt;
    logic         wrap_r;
    logic         wrap_nxt;
    logic         err_r;
    logic         err_nxt;
    logic         din_ok;

    // Load value must be all-decimal and below the modulus.
    always_comb begin
        din_ok = bcd_valid(din) && (bcd_value(din) < MODULUS);
    end

    // Next-state: load > count > hold; pulses default low.
    always_comb begin
        q_nxt    = q_r;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (load) begin
            if (din_ok) begin
                q_nxt = din;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (q_r == MAX_BCD) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = bcd_inc(q_r);
                end
            end else begin
                if (q_r == '0) begin
                    q_nxt    = MAX_BCD;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = bcd_dec(q_r);
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            wrap_r <= wrap_nxt;
            err_r  <= err_nxt;
        end
    end

    assign Q    = q_r;
    assign wrap = wrap_r;
    assign err  = err_r;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed testbench for bcd_mod_counter: defaults (mod 60), mod 24,
// and a mod-1000 stage cascaded into a mod-10 stage.
module tb_bcd_mod_counter;

    logic clk;
    logic rst_n;

    // Instance A: DIGITS=2, MODULUS=60
    logic        a_en, a_up, a_load;
    logic [7:0]  a_din, a_q;
    logic        a_wrap, a_err;

    // Instance B: DIGITS=2, MODULUS=24
    logic        b_en, b_up, b_load;
    logic [7:0]  b_din, b_q;
    logic        b_wrap, b_err;

    // Instance C: DIGITS=3, MODULUS=1000, drives D through its wrap
    logic        c_en, c_up, c_load;
    logic [11:0] c_din, c_q;
    logic        c_wrap, c_err;

    // Instance D: DIGITS=1, MODULUS=10, en from C's wrap
    logic [3:0]  d_din, d_q;
    logic        d_wrap, d_err;

    int total;
    int bad;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_a (
        .clk(clk), ._rst(rst_n), .en(a_en), .up(a_up), .load(a_load),
        .din(a_din), .Q(a_q), .wrap(a_wrap), .err(a_err)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_b (
        .clk(clk), ._rst(rst_n), .en(b_en), .up(b_up), .load(b_load),
        .din(b_din), .Q(b_q), .wrap(b_wrap), .err(b_err)
    );

    bcd_mod_counter #(.DIGITS(3), .MODULUS(1000)) u_c (
        .clk(clk), ._rst(rst_n), .en(c_en), .up(c_up), .load(c_load),
        .din(c_din), .Q(c_q), .wrap(c_wrap), .err(c_err)
    );

    bcd_mod_counter #(.DIGITS(1), .MODULUS(10)) u_d (
        .clk(clk), ._rst(rst_n), .en(c_wrap), .up(1'b1), .load(1'b0),
        .din(d_din), .Q(d_q), .wrap(d_wrap), .err(d_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report a mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Two-digit decimal to BCD for expected values.
    function automatic logic [31:0] bcd2(input int v);
        return 32'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        d_din = 4'h0;
        a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_din = 8'h00;
        b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_din = 8'h00;
        c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_din = 12'h000;
        rst_n = 1'b0;

        // Reset state
        #20;
        check("rst_q",    32'(a_q),    32'h0);
        check("rst_wrap", 32'(a_wrap), 32'h0);
        check("rst_err",  32'(a_err),  32'h0);
        rst_n = 1'b1;

        // Up-count through a full modulus: 01..59, then 00 with wrap
        a_en = 1'b1;
        a_up = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            check($sformatf("up_q%0d", i),    32'(a_q),    bcd2(i % 60));
            check($sformatf("up_wrap%0d", i), 32'(a_wrap), (i == 60) ? 32'h1 : 32'h0);
        end

        // Down-count from 00: 59 with wrap, then 58 .. 49
        a_up = 1'b0;
        step();
        check("dn_q0",    32'(a_q),    32'h59);
        check("dn_wrap0", 32'(a_wrap), 32'h1);
        for (int j = 1; j <= 10; j++) begin
            step();
            check($sformatf("dn_q%0d", j),    32'(a_q),    bcd2(59 - j));
            check($sformatf("dn_wrap%0d", j), 32'(a_wrap), 32'h0);
        end

        // Loads
        a_en = 1'b0; a_load = 1'b1; a_din = 8'h45;
        step();
        check("ld45_q",   32'(a_q),   32'h45);
        check("ld45_err", 32'(a_err), 32'h0);
        a_din = 8'h60;
        step();
        check("ld60_q",   32'(a_q),   32'h45);
        check("ld60_err", 32'(a_err), 32'h1);
        a_din = 8'h3A;
        step();
        check("ld3a_q",   32'(a_q),   32'h45);
        check("ld3a_err", 32'(a_err), 32'h1);
        a_en = 1'b1; a_up = 1'b1; a_din = 8'h37;
        step();
        check("ldpri_q",   32'(a_q),   32'h37);
        check("ldpri_err", 32'(a_err), 32'h0);

        // Hold for 5 cycles
        a_load = 1'b0; a_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("hold_q%0d", k),    32'(a_q),    32'h37);
            check($sformatf("hold_wrap%0d", k), 32'(a_wrap), 32'h0);
            check($sformatf("hold_err%0d", k),  32'(a_err),  32'h0);
        end

        // Mid-count reset between edges with Q=0x59 and an err pulse pending
        a_load = 1'b1; a_din = 8'h59;
        step();
        check("pre_rst_q", 32'(a_q), 32'h59);
        a_din = 8'h99;
        step();
        check("pre_rst_err", 32'(a_err), 32'h1);
        check("pre_rst_q2",  32'(a_q),   32'h59);
        a_load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_q",    32'(a_q),    32'h0);
        check("mid_rst_wrap", 32'(a_wrap), 32'h0);
        check("mid_rst_err",  32'(a_err),  32'h0);
        #1 rst_n = 1'b1;

        // Mod 24 variant
        b_load = 1'b1; b_din = 8'h22;
        step();
        check("m24_ld", 32'(b_q), 32'h22);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
        step();
        check("m24_q23",    32'(b_q),    32'h23);
        check("m24_wrap23", 32'(b_wrap), 32'h0);
        step();
        check("m24_q00",    32'(b_q),    32'h00);
        check("m24_wrap00", 32'(b_wrap), 32'h1);
        step();
        check("m24_q01",    32'(b_q),    32'h01);
        check("m24_wrap01", 32'(b_wrap), 32'h0);
        b_en = 1'b0; b_load = 1'b1; b_din = 8'h24;
        step();
        check("m24_ld24_err", 32'(b_err), 32'h1);
        check("m24_ld24_q",   32'(b_q),   32'h01);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b0;
        step();
        check("m24_dn00", 32'(b_q), 32'h00);
        step();
        check("m24_dn23",   32'(b_q),    32'h23);
        check("m24_dnwrap", 32'(b_wrap), 32'h1);
        b_en = 1'b0;

        // Mod 1000 with cascade into D
        c_load = 1'b1; c_din = 12'h998;
        step();
        check("m1k_ld", 32'(c_q), 32'h998);
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        step();
        check("m1k_q999",  32'(c_q),    32'h999);
        check("m1k_w999",  32'(c_wrap), 32'h0);
        check("casc_d0a",  32'(d_q),    32'h0);
        step();
        check("m1k_q000",  32'(c_q),    32'h000);
        check("m1k_w000",  32'(c_wrap), 32'h1);
        check("casc_d0b",  32'(d_q),    32'h0);
        step();
        check("m1k_q001",  32'(c_q),    32'h001);
        check("m1k_w001",  32'(c_wrap), 32'h0);
        check("casc_d1",   32'(d_q),    32'h1);
        c_en = 1'b0;
        step();
        check("casc_d1_hold", 32'(d_q), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
